// File: rtl/demux_x16_pkg.sv
// Shared constants and FSM state type for the bit-select mux/demux path.
// The mux and demux sides import the same constants so their index widths match.
package demux_x16_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_SEL_W = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

endpackage

// File: rtl/demux_x16_deser_if.sv
// Serial-in / parallel-out port bundle for demux_x16_deser.
// The bundle also carries the flush control and the current write index.
interface demux_x16_deser_if
  import demux_x16_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SEL_W = DEF_SEL_W
);

  logic             flush;
  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_word;
  logic [SEL_W-1:0] idx;

  modport master (
    output flush, in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_word, idx
  );

  modport slave (
    input  flush, in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_word, idx
  );

endinterface

// File: rtl/bit_index_counter.sv
// Modulo-WIDTH bit position counter; wrap flags the increment leaving the last position.
// clr has priority over inc.
module bit_index_counter
  import demux_x16_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SEL_W = DEF_SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

  assign wrap = inc && !clr && (idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= (idx == LAST) ? '0 : idx + SEL_W'(1);
    end
  end

endmodule

// File: rtl/demux_x16_deser.sv
// Bit-serial to WIDTH-bit parallel deserializer: bit k of the stream lands in out_word[k].
// The finished word is held in its own register and offered on a valid/ready port.
module demux_x16_deser
  import demux_x16_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SEL_W = DEF_SEL_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux_x16_deser_if.slave      bus
);

  state_e           state;
  state_e           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word_c;
  logic [WIDTH-1:0] out_word_q;
  logic [SEL_W-1:0] idx;
  logic             accept;
  logic             wrap;
  logic             in_ready_c;
  logic             out_valid_c;

  // Flush wins over a bit offered in the same cycle.
  assign accept = bus.in_valid && in_ready_c && !bus.flush;

  bit_index_counter #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_idx (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept),
    .clr   (bus.flush),
    .idx   (idx),
    .wrap  (wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // A wrap can only happen in COLLECT; any handoff in FULL returns to COLLECT.
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (wrap)          state_nxt = FULL;
      FULL:    if (bus.out_ready) state_nxt = COLLECT;
      default:                    state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    in_ready_c  = 1'b1;
    out_valid_c = 1'b0;
    if (state == FULL) begin
      in_ready_c  = bus.out_ready;
      out_valid_c = 1'b1;
    end
  end

  // Partial word with the current bit dropped into its slot.
  always_comb begin
    word_c      = shreg;
    word_c[idx] = bus.in_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (bus.flush) begin
      shreg <= '0;
    end else if (accept) begin
      shreg <= wrap ? '0 : word_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_word_q <= '0;
    end else if (wrap) begin
      out_word_q <= word_c;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_word  = out_word_q;
  assign bus.idx       = idx;

endmodule

// File: tb/tb_demux_x16_deser.sv
// Directed bench for demux_x16_deser: a word-level model checked every cycle,
// plus hand-computed literal expectations at the scenario boundaries.
module tb_demux_x16_deser;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   cyc;

  demux_x16_deser_if #(.WIDTH(16), .SEL_W(4)) bus ();

  demux_x16_deser #(.WIDTH(16), .SEL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word-level model: count of collected bits, partial value, held word.
  logic        m_held;
  logic [15:0] m_word;
  logic [15:0] m_part;
  int          m_pos;

  always @(posedge clk or negedge rst_n) begin
    logic rdy;
    logic acc;
    if (!rst_n) begin
      m_held = 1'b0;
      m_word = 16'h0;
      m_part = 16'h0;
      m_pos  = 0;
    end else begin
      rdy = !m_held || bus.out_ready;
      acc = bus.in_valid && rdy && !bus.flush;
      if (m_held && bus.out_ready) m_held = 1'b0;
      if (bus.flush) begin
        m_pos  = 0;
        m_part = 16'h0;
      end else if (acc) begin
        m_part = m_part | (16'(bus.in_bit) << m_pos);
        m_pos++;
        if (m_pos == 16) begin
          m_word = m_part;
          m_held = 1'b1;
          m_pos  = 0;
          m_part = 16'h0;
        end
      end
    end
  end

  // Handoff log and in_ready-low counter for the streaming scenario.
  logic [15:0] got_w[$];
  int          got_c[$];
  logic        burst;
  int          rdy_low;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready",  32'(bus.in_ready),  32'(!m_held || bus.out_ready));
      chk("out_valid", 32'(bus.out_valid), 32'(m_held));
      chk("out_word",  32'(bus.out_word),  32'(m_word));
      chk("idx",       32'(bus.idx),       32'(m_pos));
      if (bus.out_valid && bus.out_ready) begin
        got_w.push_back(bus.out_word);
        got_c.push_back(cyc);
      end
      if (burst && !bus.in_ready) rdy_low++;
    end
  end

  task automatic drive(input logic v, input logic b, input logic r, input logic f);
    @(posedge clk);
    #2;
    bus.in_valid  = v;
    bus.in_bit    = b;
    bus.out_ready = r;
    bus.flush     = f;
    #1;
  endtask

  task automatic send_word(input logic [15:0] w, input logic r);
    for (int k = 0; k < 16; k++) drive(1'b1, w[k], r, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_word"},  32'(bus.out_word),  32'h0000);
    chk({tag, "_idx"},       32'(bus.idx),       32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc = 0;
    burst = 1'b0;
    rdy_low = 0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;

    // Reset then idle
    repeat (2) @(posedge clk);
    #2;
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Single word 0x0001 held under backpressure, flush must not drop it
    send_word(16'h0001, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("w0001_word",  32'(bus.out_word),  32'h0001);
    chk("w0001_valid", 32'(bus.out_valid), 32'd1);
    chk("w0001_ready", 32'(bus.in_ready),  32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_full_word", 32'(bus.out_word), 32'h0001);
    chk("flush_full_idx",  32'(bus.idx),      32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);

    // Only bit 15 set
    send_word(16'h8000, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("w8000_word",  32'(bus.out_word),  32'h8000);
    chk("w8000_valid", 32'(bus.out_valid), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("w8000_released", 32'(bus.out_valid), 32'd0);

    // Back-to-back words with out_ready held high
    got_w.delete();
    got_c.delete();
    rdy_low = 0;
    burst = 1'b1;
    send_word(16'hA5A5, 1'b1);
    send_word(16'h3C3C, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    burst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_count", 32'(got_w.size()), 32'd2);
    chk("b2b_w0",    32'(got_w[0]),     32'hA5A5);
    chk("b2b_w1",    32'(got_w[1]),     32'h3C3C);
    chk("b2b_gap",   32'(got_c[1] - got_c[0]), 32'd16);
    chk("b2b_rdy_low", 32'(rdy_low), 32'd0);

    // Backpressure: held 0x1234, then next word's bit 0 accepted on release
    send_word(16'h1234, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      chk("bp_word", 32'(bus.out_word), 32'h1234);
      chk("bp_idx",  32'(bus.idx),      32'd0);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_next_idx",   32'(bus.idx),       32'd1);
    chk("bp_next_valid", 32'(bus.out_valid), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // Flush mid-word, then a word of zeros
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    chk("flush_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_idx", 32'(bus.idx), 32'd0);
    send_word(16'h0000, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_word",  32'(bus.out_word),  32'h0000);
    chk("flush_valid", 32'(bus.out_valid), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset after 9 bits
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    chk("pre_reset_idx", 32'(bus.idx), 32'd9);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    send_word(16'hFFFF, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("post_reset_word",  32'(bus.out_word),  32'hFFFF);
    chk("post_reset_valid", 32'(bus.out_valid), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
